// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Stall vectors are indexed [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_FROM_ID = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_FROM_EX = 6'b001111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_MULTI = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall vector, multi-cycle EX
// countdown, timed exception flush with redirect PC, and a stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_from_id,
    input  logic                stallreq_from_ex,
    input  logic                ex_multi_start,
    input  logic [CNT_W-1:0]    ex_multi_cycles,
    input  logic                excp_valid,
    input  logic [31:0]         excp_pc,
    output logic [STALL_W-1:0]  stall,
    output logic                ex_multi_last,
    output logic                ex_busy,
    output logic                flush,
    output logic [31:0]         flush_pc,
    output logic [31:0]         stall_cycles
);

    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    ctrl_state_e        state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [2:0]         fcnt_q, fcnt_d;
    logic               flush_q, flush_d;
    logic [31:0]        flush_pc_q, flush_pc_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= CTRL_IDLE;
            rem_q          <= '0;
            fcnt_q         <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= ZERO_WORD;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            fcnt_q         <= fcnt_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        fcnt_d        = fcnt_q;
        flush_d       = flush_q;
        flush_pc_d    = flush_pc_q;
        stall         = STALL_NONE;
        ex_multi_last = 1'b0;
        ex_busy       = 1'b0;

        // Combinational outputs are forced quiet while reset is held.
        if (!rst) begin
            unique case (state_q)
                CTRL_IDLE, CTRL_MULTI: begin
                    if (excp_valid) begin
                        flush_d    = 1'b1;
                        flush_pc_d = excp_pc;
                        fcnt_d     = FCNT_INIT;
                        rem_d      = '0;
                        state_d    = CTRL_FLUSH;
                    end else if (state_q == CTRL_MULTI && rem_q != '0) begin
                        ex_busy = 1'b1;
                        stall   = STALL_FROM_EX;
                        rem_d   = rem_q - 1'b1;
                    end else begin
                        // Final MULTI cycle: EX advances, so IDLE request rules apply.
                        if (state_q == CTRL_MULTI) begin
                            ex_busy       = 1'b1;
                            ex_multi_last = 1'b1;
                            state_d       = CTRL_IDLE;
                        end
                        if (state_q == CTRL_IDLE && ex_multi_start && ex_multi_cycles > CNT_W'(1)) begin
                            ex_busy = 1'b1;
                            stall   = STALL_FROM_EX;
                            rem_d   = ex_multi_cycles - CNT_W'(2);
                            state_d = CTRL_MULTI;
                        end else begin
                            if (state_q == CTRL_IDLE && ex_multi_start)
                                ex_multi_last = 1'b1;
                            if (stallreq_from_ex)
                                stall = STALL_FROM_EX;
                            else if (stallreq_from_id)
                                stall = STALL_FROM_ID;
                        end
                    end
                end
                CTRL_FLUSH: begin
                    if (fcnt_q == '0) begin
                        flush_d = 1'b0;
                        state_d = CTRL_IDLE;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
                default: state_d = CTRL_IDLE;
            endcase
        end

        stall_cycles_d = stall_cycles_q;
        if (stall[0] && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_from_id = 1'b0;
    logic        stallreq_from_ex = 1'b0;
    logic        ex_multi_start = 1'b0;
    logic [5:0]  ex_multi_cycles = '0;
    logic        excp_valid = 1'b0;
    logic [31:0] excp_pc = '0;
    logic [5:0]  stall;
    logic        ex_multi_last;
    logic        ex_busy;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] stall_cycles;

    pipe_ctrl #(.CNT_W(6), .FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (stallreq_from_id),
        .stallreq_from_ex (stallreq_from_ex),
        .ex_multi_start   (ex_multi_start),
        .ex_multi_cycles  (ex_multi_cycles),
        .excp_valid       (excp_valid),
        .excp_pc          (excp_pc),
        .stall            (stall),
        .ex_multi_last    (ex_multi_last),
        .ex_busy          (ex_busy),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        last;
        logic        busy;
        logic        flush;
        logic [31:0] fpc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_passed = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name,
                      {stall, ex_multi_last, ex_busy, flush, flush_pc, stall_cycles},
                      {e.stall, e.last, e.busy, e.flush, e.fpc, e.sc});
            end
        end
    end

    // Drive one cycle's inputs and queue the outputs expected during it.
    task automatic step(input string nm, input logic id, input logic ex,
                        input logic ms, input logic [5:0] n,
                        input logic ev, input logic [31:0] epc,
                        input logic [5:0] e_stall, input logic e_last,
                        input logic e_busy, input logic e_flush,
                        input logic [31:0] e_fpc, input logic [31:0] e_sc);
        exp_t e;
        stallreq_from_id = id;
        stallreq_from_ex = ex;
        ex_multi_start   = ms;
        ex_multi_cycles  = n;
        excp_valid       = ev;
        excp_pc          = epc;
        e = '{nm, e_stall, e_last, e_busy, e_flush, e_fpc, e_sc};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset held: combinational outputs gated even with a request present.
        step("rst_gate",  1,0,0,0,0,0,        6'b000000,0,0,0,32'h0,0);
        rst = 1'b0;

        step("id_1",      1,0,0,0,0,0,        6'b000111,0,0,0,32'h0,0);
        step("id_2",      1,0,0,0,0,0,        6'b000111,0,0,0,32'h0,1);
        step("id_3",      1,0,0,0,0,0,        6'b000111,0,0,0,32'h0,2);
        step("id_done",   0,0,0,0,0,0,        6'b000000,0,0,0,32'h0,3);

        step("m4_start",  0,0,1,6'd4,0,0,     6'b001111,0,1,0,32'h0,3);
        step("m4_c2",     0,0,0,0,0,0,        6'b001111,0,1,0,32'h0,4);
        step("m4_c3",     1,0,0,0,0,0,        6'b001111,0,1,0,32'h0,5);
        step("m4_last",   0,0,0,0,0,0,        6'b000000,1,1,0,32'h0,6);
        step("m4_after",  0,0,0,0,0,0,        6'b000000,0,0,0,32'h0,6);

        step("n1_start",  0,0,1,6'd1,0,0,     6'b000000,1,0,0,32'h0,6);
        step("n1_idle",   0,1,0,0,0,0,        6'b001111,0,0,0,32'h0,6);
        step("n0_start",  0,0,1,6'd0,0,0,     6'b000000,1,0,0,32'h0,7);
        step("n0_idle",   0,0,0,0,0,0,        6'b000000,0,0,0,32'h0,7);

        step("m5_start",  0,0,1,6'd5,0,0,     6'b001111,0,1,0,32'h0,7);
        step("m5_c2",     0,0,0,0,0,0,        6'b001111,0,1,0,32'h0,8);
        step("m5_excp",   0,0,0,0,1,32'h20,   6'b000000,0,0,0,32'h0,9);
        step("m5_fl1",    0,0,0,0,0,0,        6'b000000,0,0,1,32'h20,9);
        step("m5_fl2",    0,0,0,0,0,0,        6'b000000,0,0,1,32'h20,9);
        step("m5_after",  0,0,0,0,0,0,        6'b000000,0,0,0,32'h20,9);

        step("sim_all",   1,0,1,6'd3,1,32'h40, 6'b000000,0,0,0,32'h20,9);
        step("sim_fl1",   0,1,1,6'd3,1,32'h80, 6'b000000,0,0,1,32'h40,9);
        step("sim_fl2",   0,0,1,6'd3,0,0,      6'b000000,0,0,1,32'h40,9);
        step("sim_after", 0,0,0,0,0,0,         6'b000000,0,0,0,32'h40,9);

        step("ar_start",  0,0,1,6'd4,0,0,     6'b001111,0,1,0,32'h40,9);
        #2;
        rst = 1'b1;
        step("ar_held",   1,0,0,0,0,0,        6'b000000,0,0,0,32'h0,0);
        rst = 1'b0;
        step("n2_start",  0,0,1,6'd2,0,0,     6'b001111,0,1,0,32'h0,0);
        step("n2_last",   0,0,0,0,0,0,        6'b000000,1,1,0,32'h0,1);
        step("n2_after",  0,0,0,0,0,0,        6'b000000,0,0,0,32'h0,1);

        @(negedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
